// File: rtl/rtc_pkg.sv
// rtc_pkg: RTC register map, status/interrupt bit positions and the
// init-sequencer state/step types shared by the APB init logic.
package rtc_pkg;

    localparam logic [31:0] RTC_CTRL_ADDR = 32'h0000_0000;
    localparam logic [31:0] RTC_PSCR_ADDR = 32'h0000_0004;
    localparam logic [31:0] RTC_CNT_ADDR  = 32'h0000_0008;
    localparam logic [31:0] RTC_ALRM_ADDR = 32'h0000_000C;
    localparam logic [31:0] RTC_ISTA_ADDR = 32'h0000_0010;
    localparam logic [31:0] RTC_SSTA_ADDR = 32'h0000_0014;

    localparam int ISTA_SEC   = 0;
    localparam int ISTA_ALRM  = 1;
    localparam int ISTA_OV    = 2;
    localparam int SSTA_LWOFF = 1;
    localparam int CTRL_CMF   = 0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_XFER_CTRL_ENTER,
        ST_POLL,
        ST_XFER_PSCR,
        ST_XFER_CNT,
        ST_XFER_ALRM,
        ST_XFER_CTRL_EXIT,
        ST_RUN,
        ST_IRQ_RD,
        ST_IRQ_WR
    } state_e;

    typedef enum logic [1:0] {
        STEP_PSCR,
        STEP_CNT,
        STEP_ALRM,
        STEP_EXIT
    } step_e;

    function automatic state_e step_state(input step_e s);
        return s == STEP_PSCR ? ST_XFER_PSCR :
               s == STEP_CNT  ? ST_XFER_CNT  :
               s == STEP_ALRM ? ST_XFER_ALRM : ST_XFER_CTRL_EXIT;
    endfunction

endpackage

// File: rtl/rtc_apb_xfer.sv
// rtc_apb_xfer: single APB transfer engine; one SETUP cycle, then ACCESS
// held until pready_i, with address/direction/data latched for the whole transfer.
module rtc_apb_xfer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] paddr_o,
    output logic [31:0] pwdata_o,
    input  logic [31:0] prdata_i,
    input  logic        pready_i,
    input  logic        pslverr_i
);

    localparam logic [1:0] X_IDLE = 2'd0, X_SETUP = 2'd1, X_ACCESS = 2'd2;

    logic [1:0]  st_q, st_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    always_comb begin
        st_d    = st_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (st_q == X_IDLE && req_i) begin
            st_d    = X_SETUP;
            we_d    = we_i;
            addr_d  = addr_i;
            wdata_d = wdata_i;
        end else if (st_q == X_SETUP) begin
            st_d = X_ACCESS;
        end else if (st_q == X_ACCESS && pready_i) begin
            st_d = X_IDLE;
        end
    end

    // psel/penable come straight from state flops so reset drops them at once
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q    <= X_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            st_q    <= st_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign psel_o    = st_q != X_IDLE;
    assign penable_o = st_q == X_ACCESS;
    assign pwrite_o  = we_q;
    assign paddr_o   = addr_q;
    assign pwdata_o  = wdata_q;
    assign done_o    = st_q == X_ACCESS && pready_i;
    assign err_o     = done_o && pslverr_i;
    assign rdata_o   = prdata_i;

endmodule

// File: rtl/rtc_apb_init.sv
// rtc_apb_init: programs the RTC over APB (CTRL/PSCR/CNT/ALRM with LWOFF polls)
// and, once running, services RTC interrupts by reading and clearing ISTA.
module rtc_apb_init
    import rtc_pkg::*;
#(
    parameter int POLL_MAX = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [4:0]  ctrl_i,
    input  logic [19:0] pscr_i,
    input  logic [31:0] cnt_i,
    input  logic [31:0] alrm_i,
    input  logic        irq_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        sec_evt_o,
    output logic        alrm_evt_o,
    output logic        ov_evt_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] paddr_o,
    output logic [31:0] pwdata_o,
    input  logic [31:0] prdata_i,
    input  logic        pready_i,
    input  logic        pslverr_i
);

    localparam int PW = $clog2(POLL_MAX + 1);

    state_e        state_q, state_d;
    step_e         ret_q, ret_d;
    logic [PW-1:0] poll_q, poll_d;
    logic          iss_q, iss_d;
    logic [3:0]    ctrl_q, ctrl_d;
    logic [19:0]   pscr_q, pscr_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   alrm_q, alrm_d;
    logic [2:0]    ista_q, ista_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          x_req, x_we, x_done, x_err, in_xfer, wr_ok;
    logic [31:0]   x_addr, x_wdata, x_rdata;
    logic          unused_bits;

    assign in_xfer = !(state_q inside {ST_IDLE, ST_RUN});
    assign x_req   = in_xfer && !iss_q;
    assign x_we    = !(state_q inside {ST_POLL, ST_IRQ_RD});
    assign x_addr  = state_q == ST_POLL                        ? RTC_SSTA_ADDR :
                     state_q == ST_XFER_PSCR                   ? RTC_PSCR_ADDR :
                     state_q == ST_XFER_CNT                    ? RTC_CNT_ADDR  :
                     state_q == ST_XFER_ALRM                   ? RTC_ALRM_ADDR :
                     state_q inside {ST_IRQ_RD, ST_IRQ_WR}     ? RTC_ISTA_ADDR : RTC_CTRL_ADDR;
    // ISTA is RC_W0: writing 0 clears, so only the bits seen in the read are zeroed
    assign x_wdata = state_q == ST_XFER_PSCR ? {12'b0, pscr_q} :
                     state_q == ST_XFER_CNT  ? cnt_q :
                     state_q == ST_XFER_ALRM ? alrm_q :
                     state_q == ST_IRQ_WR    ? {29'b0, ~ista_q} :
                     {27'b0, ctrl_q, state_q == ST_XFER_CTRL_ENTER};

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        poll_d  = poll_q;
        iss_d   = iss_q;
        ctrl_d  = ctrl_q;
        pscr_d  = pscr_q;
        cnt_d   = cnt_q;
        alrm_d  = alrm_q;
        ista_d  = ista_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (x_req)
            iss_d = 1'b1;
        if (x_done)
            iss_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (state_q == ST_RUN && irq_i) begin
                    state_d = ST_IRQ_RD;
                end else if (start_i) begin
                    ctrl_d  = ctrl_i[4:1];
                    pscr_d  = pscr_i;
                    cnt_d   = cnt_i;
                    alrm_d  = alrm_i;
                    err_d   = pscr_i < 20'd2;
                    state_d = err_d ? ST_IDLE : ST_XFER_CTRL_ENTER;
                end
            end
            ST_XFER_CTRL_ENTER, ST_XFER_PSCR, ST_XFER_CNT, ST_XFER_ALRM: begin
                if (x_done) begin
                    state_d = ST_POLL;
                    ret_d   = state_q == ST_XFER_CTRL_ENTER ? STEP_PSCR :
                              state_q == ST_XFER_PSCR       ? STEP_CNT  :
                              state_q == ST_XFER_CNT        ? STEP_ALRM : STEP_EXIT;
                end
            end
            ST_POLL: begin
                if (x_done) begin
                    if (x_rdata[SSTA_LWOFF]) begin
                        state_d = step_state(ret_q);
                    end else if (poll_q == PW'(POLL_MAX - 1)) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        poll_d = poll_q + PW'(1);
                    end
                end
            end
            ST_XFER_CTRL_EXIT: begin
                if (x_done) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end
            end
            ST_IRQ_RD: begin
                if (x_done) begin
                    ista_d  = x_rdata[2:0];
                    state_d = x_rdata[2:0] == 3'b000 ? ST_RUN : ST_IRQ_WR;
                end
            end
            ST_IRQ_WR: begin
                if (x_done)
                    state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
        // a slave error on any completion abandons whatever step was in flight
        if (x_err) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            err_d   = 1'b1;
        end
        if (state_d != ST_POLL)
            poll_d = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ret_q   <= STEP_PSCR;
            poll_q  <= '0;
            iss_q   <= 1'b0;
            ctrl_q  <= '0;
            pscr_q  <= '0;
            cnt_q   <= '0;
            alrm_q  <= '0;
            ista_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            poll_q  <= poll_d;
            iss_q   <= iss_d;
            ctrl_q  <= ctrl_d;
            pscr_q  <= pscr_d;
            cnt_q   <= cnt_d;
            alrm_q  <= alrm_d;
            ista_q  <= ista_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    rtc_apb_xfer u_xfer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (x_req),
        .we_i      (x_we),
        .addr_i    (x_addr),
        .wdata_i   (x_wdata),
        .done_o    (x_done),
        .err_o     (x_err),
        .rdata_o   (x_rdata),
        .psel_o    (psel_o),
        .penable_o (penable_o),
        .pwrite_o  (pwrite_o),
        .paddr_o   (paddr_o),
        .pwdata_o  (pwdata_o),
        .prdata_i  (prdata_i),
        .pready_i  (pready_i),
        .pslverr_i (pslverr_i)
    );

    assign wr_ok      = state_q == ST_IRQ_WR && x_done && !x_err;
    assign sec_evt_o  = wr_ok && ista_q[ISTA_SEC];
    assign alrm_evt_o = wr_ok && ista_q[ISTA_ALRM];
    assign ov_evt_o   = wr_ok && ista_q[ISTA_OV];
    assign busy_o     = in_xfer;
    assign done_o     = done_q;
    assign err_o      = err_q;
    // CMF is always forced by the sequence; only low status bits are ever read
    assign unused_bits = ^{ctrl_i[CTRL_CMF], x_rdata[31:3]};

endmodule

// File: tb/tb_rtc_apb_init.sv
// tb_rtc_apb_init: directed bench with a small APB RTC slave model; all
// expectations are hand-derived transfer lists and pulse counts.
module tb_rtc_apb_init;
    import rtc_pkg::*;

    logic        clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0;
    logic [4:0]  ctrl_i = '0;
    logic [19:0] pscr_i = '0;
    logic [31:0] cnt_i = '0, alrm_i = '0;
    logic        irq_i, busy_o, done_o, err_o, sec_evt_o, alrm_evt_o, ov_evt_o;
    logic        psel_o, penable_o, pwrite_o, pready_i, pslverr_i;
    logic [31:0] paddr_o, pwdata_o, prdata_i;

    int n_chk = 0, n_fail = 0;

    // slave model knobs
    logic        lwoff = 1'b1, irq_force = 1'b0, alrm_at_wr = 1'b0;
    logic [2:0]  ista = 3'b000;
    logic [31:0] wait_addr = 32'hFFFF_FFFF, err_addr = 32'hFFFF_FFFF;
    int          wait_n = 0, acc_cnt = 0;

    logic        log_we[$];
    logic [31:0] log_addr[$], log_wd[$];
    int n_done, n_errp, n_sec, n_alrm, n_ov, n_psel, n_acc;

    logic [31:0] e_addr[9] = '{RTC_CTRL_ADDR, RTC_SSTA_ADDR, RTC_PSCR_ADDR, RTC_SSTA_ADDR,
                               RTC_CNT_ADDR, RTC_SSTA_ADDR, RTC_ALRM_ADDR, RTC_SSTA_ADDR, RTC_CTRL_ADDR};
    logic [31:0] e_wd[9]   = '{32'h15, 32'h0, 32'h8000, 32'h0, 32'h0, 32'h0, 32'hA, 32'h0, 32'h14};

    rtc_apb_init #(.POLL_MAX(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .ctrl_i(ctrl_i), .pscr_i(pscr_i),
        .cnt_i(cnt_i), .alrm_i(alrm_i), .irq_i(irq_i), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .sec_evt_o(sec_evt_o), .alrm_evt_o(alrm_evt_o), .ov_evt_o(ov_evt_o),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
        .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    always #5 clk_i = ~clk_i;

    assign irq_i     = irq_force || (|ista);
    assign pready_i  = psel_o && penable_o && acc_cnt >= (paddr_o == wait_addr ? wait_n : 0);
    assign pslverr_i = pready_i && paddr_o == err_addr;
    assign prdata_i  = paddr_o == RTC_SSTA_ADDR ? {30'b0, lwoff, 1'b0} :
                       paddr_o == RTC_ISTA_ADDR ? {29'b0, ista} : 32'h0;

    always @(posedge clk_i) acc_cnt <= (psel_o && penable_o && !pready_i) ? acc_cnt + 1 : 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // one cycle: wait for the falling edge, then sample and update the slave model
    task automatic tick();
        @(negedge clk_i);
        n_psel += int'(psel_o);
        n_acc  += int'(psel_o && penable_o);
        if (psel_o && penable_o && pready_i) begin
            log_we.push_back(pwrite_o);
            log_addr.push_back(paddr_o);
            log_wd.push_back(pwdata_o);
            if (pwrite_o && paddr_o == RTC_ISTA_ADDR && !pslverr_i) begin
                ista = ista & pwdata_o[2:0];
                alrm_at_wr = alrm_evt_o;
            end
        end
        n_done += int'(done_o);
        n_errp += int'(err_o);
        n_sec  += int'(sec_evt_o);
        n_alrm += int'(alrm_evt_o);
        n_ov   += int'(ov_evt_o);
    endtask

    task automatic clear();
        log_we.delete(); log_addr.delete(); log_wd.delete();
        n_done = 0; n_errp = 0; n_sec = 0; n_alrm = 0; n_ov = 0; n_psel = 0; n_acc = 0;
        alrm_at_wr = 1'b0;
    endtask

    task automatic run_until_end(input int lim, input string tag);
        int k = 0;
        while (n_done + n_errp == 0 && k < lim) begin
            tick();
            k++;
        end
        chk({tag, "_ended"}, 32'(n_done + n_errp != 0), 32'd1);
    endtask

    task automatic expect_xfer(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
        if (i >= log_addr.size()) begin
            chk($sformatf("xfer%0d_present", i), 32'(log_addr.size()), 32'(i + 1));
        end else begin
            chk($sformatf("xfer%0d_we", i), 32'(log_we[i]), 32'(we));
            chk($sformatf("xfer%0d_addr", i), log_addr[i], a);
            if (we) chk($sformatf("xfer%0d_wdata", i), log_wd[i], d);
        end
    endtask

    task automatic do_start(input logic [19:0] p);
        ctrl_i = 5'b10100; pscr_i = p; cnt_i = 32'd0; alrm_i = 32'd10;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        int nw;
        logic found;
        clear();
        repeat (3) tick();
        chk("rst_ctl", {23'b0, psel_o, penable_o, pwrite_o, busy_o, done_o, err_o, sec_evt_o, alrm_evt_o, ov_evt_o}, 32'd0);
        chk("rst_paddr", paddr_o, 32'd0);
        chk("rst_pwdata", pwdata_o, 32'd0);
        rst_i = 1'b0;
        repeat (5) tick();
        chk("no_autostart", 32'(n_psel), 32'd0);

        // full programming sequence
        clear();
        do_start(20'h8000);
        chk("prog_busy", 32'(busy_o), 32'd1);
        run_until_end(200, "prog");
        tick();
        chk("prog_nxfer", 32'(log_addr.size()), 32'd9);
        for (int i = 0; i < 9; i++) expect_xfer(i, (i % 2) == 0, e_addr[i], e_wd[i]);
        chk("prog_done", 32'(n_done), 32'd1);
        chk("prog_err", 32'(n_errp), 32'd0);
        chk("prog_run_idle", 32'(busy_o), 32'd0);

        // irq with start in the same RUN cycle: irq wins, start dropped
        clear();
        ista = 3'b010;
        do_start(20'h8000);
        repeat (40) tick();
        chk("irq_nxfer", 32'(log_addr.size()), 32'd2);
        expect_xfer(0, 1'b0, RTC_ISTA_ADDR, 32'h0);
        expect_xfer(1, 1'b1, RTC_ISTA_ADDR, 32'h5);
        chk("irq_alrm", 32'(n_alrm), 32'd1);
        chk("irq_alrm_at_wr", 32'(alrm_at_wr), 32'd1);
        chk("irq_sec_ov", 32'(n_sec + n_ov), 32'd0);
        chk("irq_no_done", 32'(n_done), 32'd0);

        // ISTA reads zero: no write, no events
        clear();
        irq_force = 1'b1;
        repeat (12) tick();
        irq_force = 1'b0;
        repeat (10) tick();
        nw = 0;
        foreach (log_we[i]) nw += int'(log_we[i]);
        chk("ista0_reads", 32'(log_addr.size() >= 2), 32'd1);
        chk("ista0_writes", 32'(nw), 32'd0);
        chk("ista0_events", 32'(n_sec + n_alrm + n_ov), 32'd0);
        chk("ista0_idle", 32'(busy_o), 32'd0);

        // prescaler below 2 rejected without bus activity
        clear();
        do_start(20'd1);
        chk("pscr_err_pulse", 32'(err_o), 32'd1);
        tick();
        chk("pscr_err_once", 32'(err_o), 32'd0);
        repeat (5) tick();
        chk("pscr_no_psel", 32'(n_psel), 32'd0);

        // LWOFF stuck low: POLL_MAX reads then timeout
        clear();
        lwoff = 1'b0;
        do_start(20'h8000);
        run_until_end(200, "poll");
        repeat (10) tick();
        chk("poll_nxfer", 32'(log_addr.size()), 32'd5);
        expect_xfer(0, 1'b1, RTC_CTRL_ADDR, 32'h15);
        for (int i = 1; i < 5; i++) expect_xfer(i, 1'b0, RTC_SSTA_ADDR, 32'h0);
        chk("poll_err", 32'(n_errp), 32'd1);
        chk("poll_no_done", 32'(n_done), 32'd0);
        chk("poll_idle", 32'(busy_o), 32'd0);

        // wait states then slave error on PSCR
        clear();
        lwoff = 1'b1; wait_addr = RTC_PSCR_ADDR; wait_n = 3; err_addr = RTC_PSCR_ADDR;
        do_start(20'h8000);
        run_until_end(200, "slverr");
        repeat (20) tick();
        chk("slverr_nxfer", 32'(log_addr.size()), 32'd3);
        expect_xfer(2, 1'b1, RTC_PSCR_ADDR, 32'h8000);
        chk("slverr_access_cycles", 32'(n_acc), 32'd6);
        chk("slverr_err", 32'(n_errp), 32'd1);
        chk("slverr_no_done", 32'(n_done), 32'd0);

        // reset in the middle of an ACCESS phase
        clear();
        err_addr = 32'hFFFF_FFFF; wait_n = 50;
        do_start(20'h8000);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            found = psel_o && penable_o && paddr_o == RTC_PSCR_ADDR;
        end
        chk("rstmid_reached", 32'(found), 32'd1);
        #3 rst_i = 1'b1;
        #1 chk("rstmid_apb_drop", {30'b0, psel_o, penable_o}, 32'd0);
        chk("rstmid_busy", 32'(busy_o), 32'd0);
        tick(); tick();
        rst_i = 1'b0;
        clear();
        repeat (30) tick();
        chk("rstmid_no_done", 32'(n_done), 32'd0);
        chk("rstmid_no_psel", 32'(n_psel), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
        $finish;
    end

endmodule
